// File: rtl/fdiv_arbiter.sv
// rtl/fdiv_arbiter.sv - two-requester round-robin arbiter in front of a shared fixed-latency divider core
// Operands are held in registers for LAT cycles, then the core result is captured into a response slot.
module fdiv_arbiter #(
  parameter int NEXP = 8,
  parameter int NSIG = 23,
  parameter int LAT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [NEXP+NSIG:0]       req0_a,
  input  logic [NEXP+NSIG:0]       req0_b,
  input  logic                     req0_rm,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [NEXP+NSIG:0]       req1_a,
  input  logic [NEXP+NSIG:0]       req1_b,
  input  logic                     req1_rm,
  output logic [NEXP+NSIG:0]       core_a,
  output logic [NEXP+NSIG:0]       core_b,
  output logic                     core_rm,
  input  logic [NEXP+NSIG:0]       core_y,
  input  logic [4:0]               core_flags,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [NEXP+NSIG:0]       rsp_y,
  output logic [4:0]               rsp_flags,
  output logic [4:0]               fflags,
  input  logic                     flags_clr,
  output logic                     busy
);

  localparam int W = 1 + NEXP + NSIG;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_last_grant;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_rm;
  logic         r_id;
  logic [W-1:0] r_rsp_y;
  logic [4:0]   r_rsp_flags;
  logic         r_rsp_id;
  logic [4:0]   r_fflags;

  logic         w_idle;
  logic         w_grant;
  logic         w_acc;
  logic         w_cap;

  // Lone requester wins outright; on contention (or no request) the one not granted last time is favoured.
  always_comb begin
    w_grant = ~r_last_grant;
    if (req0_valid && !req1_valid)
      w_grant = 1'b0;
    else if (req1_valid && !req0_valid)
      w_grant = 1'b1;
  end

  assign w_idle     = (r_state == S_IDLE);
  assign req0_ready = w_idle && !w_grant;
  assign req1_ready = w_idle && w_grant;
  assign w_acc      = w_grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign w_cap      = (r_state == S_BUSY) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_rm         <= 1'b0;
      r_id         <= 1'b0;
      r_rsp_y      <= '0;
      r_rsp_flags  <= '0;
      r_rsp_id     <= 1'b0;
      r_fflags     <= '0;
    end else begin
      // Clear first, then OR in, so flags captured during a clear cycle are kept.
      r_fflags <= (flags_clr ? 5'd0 : r_fflags) | (w_cap ? core_flags : 5'd0);
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_a          <= w_grant ? req1_a  : req0_a;
            r_b          <= w_grant ? req1_b  : req0_b;
            r_rm         <= w_grant ? req1_rm : req0_rm;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= 4'(LAT - 1);
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_rsp_y     <= core_y;
            r_rsp_flags <= core_flags;
            r_rsp_id    <= r_id;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_a    = r_a;
  assign core_b    = r_b;
  assign core_rm   = r_rm;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_flags = r_rsp_flags;
  assign fflags    = r_fflags;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb/tb_fdiv_arbiter.sv - directed self-checking bench for fdiv_arbiter
// A small table-driven core model answers the handful of operand pairs used below.
module tb_fdiv_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_rm;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_rm;
  logic [31:0] req1_a, req1_b;
  logic [31:0] core_a, core_b, core_y;
  logic        core_rm;
  logic [4:0]  core_flags;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_y;
  logic [4:0]  rsp_flags, fflags;
  logic        flags_clr, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fdiv_arbiter #(.NEXP(8), .NSIG(23), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_rm(req1_rm),
    .core_a(core_a), .core_b(core_b), .core_rm(core_rm), .core_y(core_y), .core_flags(core_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .fflags(fflags), .flags_clr(flags_clr), .busy(busy)
  );

  // Core model: flags are {invalid, div0, ovf, udf, inx}.
  always_comb begin
    core_y     = 32'h0;
    core_flags = 5'b00000;
    if (core_b[30:0] == 31'h0) begin
      if (core_a[30:0] == 31'h0) begin
        core_y     = 32'h7FC00000;
        core_flags = 5'b10000;
      end else begin
        core_y     = {core_a[31] ^ core_b[31], 31'h7F800000};
        core_flags = 5'b01000;
      end
    end else if (core_a == 32'h40C00000 && core_b == 32'h40000000) begin
      core_y = 32'h40400000;
    end else if (core_a == 32'h3F800000 && core_b == 32'h40400000) begin
      core_y     = core_rm ? 32'h3EAAAAAB : 32'h3EAAAAAA;
      core_flags = 5'b00001;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic accept_req(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic rm, input bit hold, output int waited);
    waited = 0;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_rm = rm; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_rm = rm; req1_valid = 1'b1;
    end
    while (!((id == 0) ? req0_ready : req1_ready) && waited < 20) begin
      step();
      waited++;
    end
    check("accept_timeout", 32'(waited < 20), 32'd1);
    step();
    if (!hold) begin
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  int waited, lat;
  logic seen;

  initial begin
    reset = 1'b1; rsp_ready = 1'b1; flags_clr = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_rm = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_rm = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_fflags", 32'(fflags), 32'd0);
    check("rst_rsp_y", rsp_y, 32'd0);
    check("rst_core_a", core_a, 32'd0);
    reset = 1'b0;

    // Basic divide, accepted in the first cycle out of reset
    accept_req(0, 32'h40C00000, 32'h40000000, 1'b1, 1'b0, waited);
    check("first_accept_wait", 32'(waited), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_rsp(lat);
    check("basic_latency", 32'(lat), 32'(LAT));
    check("basic_id", 32'(rsp_id), 32'd0);
    check("basic_y", rsp_y, 32'h40400000);
    check("basic_flags", 32'(rsp_flags), 32'd0);
    check("basic_fflags", 32'(fflags), 32'd0);
    step();
    check("basic_idle", 32'(busy), 32'd0);

    // Divide by zero from requester 1, then clear the sticky flags
    accept_req(1, 32'h3F800000, 32'h00000000, 1'b1, 1'b0, waited);
    wait_rsp(lat);
    check("div0_latency", 32'(lat), 32'(LAT));
    check("div0_id", 32'(rsp_id), 32'd1);
    check("div0_y", rsp_y, 32'h7F800000);
    check("div0_flags", 32'(rsp_flags), 32'b01000);
    check("div0_fflags", 32'(fflags), 32'b01000);
    step();
    check("div0_fflags_held", 32'(fflags), 32'b01000);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    check("div0_fflags_cleared", 32'(fflags), 32'd0);

    // Contention from reset: grants alternate 0,1,0,1
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_a = 32'h40C00000; req0_b = 32'h40000000; req0_rm = 1'b1;
    req1_a = 32'h3F800000; req1_b = 32'h40400000; req1_rm = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int op = 0; op < 4; op++) begin
      waited = 0;
      while (!(req0_ready || req1_ready) && waited < 20) begin
        step();
        waited++;
      end
      check($sformatf("cont_grant%0d", op), 32'({req1_ready, req0_ready}), (op % 2) ? 32'd2 : 32'd1);
      step();
      check($sformatf("cont_busy_ready%0d", op), 32'({req1_ready, req0_ready}), 32'd0);
      wait_rsp(lat);
      check($sformatf("cont_id%0d", op), 32'(rsp_id), 32'(op % 2));
      check($sformatf("cont_y%0d", op), rsp_y, (op % 2) ? 32'h3EAAAAAA : 32'h40400000);
      if (op == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      step();
    end
    check("cont_fflags", 32'(fflags), 32'b00001);

    // Backpressure in RESP; operand changes while busy are ignored
    rsp_ready = 1'b0;
    accept_req(0, 32'h3F800000, 32'h40400000, 1'b1, 1'b0, waited);
    req0_a = 32'hDEADBEEF;
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    check("bp_core_a_stable", core_a, 32'h3F800000);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_y%0d", i), rsp_y, 32'h3EAAAAAB);
      check($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd0);
      check($sformatf("bp_flags%0d", i), 32'(rsp_flags), 32'b00001);
      check($sformatf("bp_ready%0d", i), 32'({req1_ready, req0_ready}), 32'd0);
      if (i < 2) step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);

    // Reset in the second BUSY cycle abandons the operation
    accept_req(0, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, waited);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_fflags", 32'(fflags), 32'd0);
    check("rb_core_a", core_a, 32'd0);
    seen = rsp_valid;
    repeat (8) begin
      step();
      seen = seen | rsp_valid;
    end
    check("rb_no_rsp", 32'(seen), 32'd0);
    check("rb_fflags_after", 32'(fflags), 32'd0);

    // Clear in the capture cycle of 0/0 keeps the newly captured flag
    accept_req(0, 32'h3F800000, 32'h40400000, 1'b0, 1'b0, waited);
    wait_rsp(lat);
    check("clrcap_prior_y", rsp_y, 32'h3EAAAAAA);
    step();
    check("clrcap_prior_fflags", 32'(fflags), 32'b00001);
    accept_req(1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, waited);
    repeat (LAT - 1) step();
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    check("clrcap_valid", 32'(rsp_valid), 32'd1);
    check("clrcap_y", rsp_y, 32'h7FC00000);
    check("clrcap_flags", 32'(rsp_flags), 32'b10000);
    check("clrcap_fflags", 32'(fflags), 32'b10000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 Parameter NEXP, default 8, exponent width of operands.
REQ-002 Parameter NSIG, default 23, stored significand width; W = 1+NEXP+NSIG.
REQ-003 Parameter LAT, default 4, number of cycles the core operands are held stable before the result is captured; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 reqN_valid / reqN_ready  input / output  1 / 1  request handshake for requester N, where N = 0, 1.
REQ-007 reqN_a, reqN_b  input  W  dividend and divisor for requester N.
REQ-008 reqN_rm  input  1  rounding mode for requester N: 0 = truncate, 1 = nearest-even.
REQ-009 core_a, core_b  output  W  operands driven to the shared divider core; core_rm  output  1  rounding mode to the core.
REQ-010 core_y  input  W  core result; core_flags  input  5  core flags {invalid, div0, ovf, udf, inx}.
REQ-011 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-012 rsp_id  output  1  index of the requester that owns the response.
REQ-013 rsp_y  output  W  response result; rsp_flags  output  5  response flags.
REQ-014 fflags  output  5  sticky accumulated exception flags; flags_clr  input  1  clears fflags.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-017 In IDLE, grant is combinational from the valids:
- only one requester valid: that requester is granted;
- both valid: the requester not granted last time is granted (round-robin).
REQ-018 reqN_ready SHALL be 1 only in IDLE and only for the granted requester; it is 0 in BUSY and RESP.
REQ-019 When a request is accepted (valid & ready), the block SHALL, on that edge:
- latch a, b, rm and the requester id into operand registers;
- update last_grant;
- load cnt = LAT-1 and enter BUSY.
REQ-020 core_a, core_b and core_rm SHALL come directly from the operand registers and stay stable from the accept edge until the next accept.
REQ-021 In BUSY, cnt SHALL decrement by one each cycle; in the BUSY cycle with cnt == 0 the block SHALL capture core_y and core_flags into rsp_y and rsp_flags and enter RESP.
REQ-022 Accept happens at cycle k; BUSY occupies cycles k+1 .. k+LAT; rsp_valid SHALL first be 1 at cycle k+LAT+1.
REQ-023 In RESP, rsp_valid = 1 and rsp_id, rsp_y and rsp_flags SHALL hold stable; on rsp_valid & rsp_ready the block SHALL return to IDLE; no accept is possible in that same cycle.
REQ-024 The next fflags value SHALL be (flags_clr ? 0 : fflags), OR'd with core_flags in a capture cycle, so flags captured in the clear cycle survive.
REQ-025 Request inputs that change while the block is not in IDLE SHALL have no effect.

Reset
REQ-026 While reset = 1 at a clock edge, the block SHALL force:
- state = IDLE, cnt = 0, last_grant = 1 (requester 0 wins the first contest);
- operand registers, rsp_y, rsp_flags, rsp_id and fflags to 0;
- rsp_valid = 0 and busy = 0.
REQ-027 Reset asserted in BUSY or RESP SHALL abandon the operation: no response is issued and its flags are not accumulated.
REQ-028 The first accept SHALL be possible in the first cycle with reset = 0.

Verification
REQ-029 Basic divide: req0 a = 0x40C00000, b = 0x40000000, rm = 1, core modelled, rsp_ready = 1 -> at cycle accept+5:
- rsp_valid = 1, rsp_id = 0, rsp_y = 0x40400000;
- rsp_flags = 0, fflags = 0.
REQ-030 Divide by zero: req1 a = 0x3F800000, b = 0x00000000 -> rsp_y = 0x7F800000, rsp_flags = 5'b01000, fflags = 5'b01000 until flags_clr is pulsed, then 0.
REQ-031 Contention: both requesters valid continuously after reset -> grants go 0, 1, 0, 1; reqN_ready is never high for both requesters in the same cycle.
REQ-032 Backpressure: rsp_ready held at 0 for 3 cycles in RESP -> rsp_y, rsp_id and rsp_flags are stable and both readys are 0; IDLE is re-entered the cycle after rsp_ready = 1.
REQ-033 Reset is pulsed in the second BUSY cycle -> rsp_valid never rises for that operation, fflags = 0 and busy = 0 after the edge.
REQ-034 flags_clr = 1 in the capture cycle of 0/0 (core_flags = 5'b10000), with prior fflags = 5'b00001 -> fflags = 5'b10000.
